// File: rtl/TDCTypes.sv
// rtl/TDCTypes.sv - shared types for the TDC event collector and readout path
package TDCTypes;

  localparam int TDC_DATA_W = 32;
  localparam int TDC_CHAN_W = 4;

  typedef struct packed {
    logic [TDC_CHAN_W-1:0] chan;
    logic [TDC_DATA_W-1:0] timestamp;
    logic [TDC_DATA_W-1:0] tot;
  } tdc_event_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CLEAR
  } collector_state_t;

endpackage

// File: rtl/tdc_event_fifo.sv
// rtl/tdc_event_fifo.sv - first-word-fall-through FIFO of TDC events
module tdc_event_fifo
  import TDCTypes::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  tdc_event_t       push_data,
  input  logic             pop,
  output tdc_event_t       head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  tdc_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is zeroed when empty so the stream fields read as zero with valid low.
  assign head = empty ? '0 : mem[rd_ptr];

  // Payload storage; no reset needed since only occupied entries are visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tdc_event_collector.sv
// rtl/tdc_event_collector.sv - round-robin TDC channel reader feeding an event stream
module tdc_event_collector
  import TDCTypes::*;
#(
  parameter  int N_CHANNELS    = 4,
  parameter  int FIFO_DEPTH    = 8,
  parameter  int CLEAR_TIMEOUT = 15,
  localparam int LEVEL_W       = $clog2(FIFO_DEPTH) + 1,
  localparam int CNT_W         = $clog2(CLEAR_TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_CHANNELS-1:0]      tdc_has_event,
  input  logic [32*N_CHANNELS-1:0]   tdc_timestamp,
  input  logic [32*N_CHANNELS-1:0]   tdc_tot,
  output logic [N_CHANNELS-1:0]      tdc_clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [3:0]                 evt_chan,
  output logic [31:0]                evt_timestamp,
  output logic [31:0]                evt_tot,
  output logic [LEVEL_W-1:0]         fifo_level,
  output logic                       clear_error
);

  logic [N_CHANNELS-1:0] has_meta;
  logic [N_CHANNELS-1:0] has_sync;

  collector_state_t state, state_n;
  logic [3:0]       sel, sel_n;
  logic [3:0]       rr_ptr, rr_n;
  logic [CNT_W-1:0] clr_cnt, cnt_n;
  logic             err_n;

  logic             found;
  logic [3:0]       pick;
  logic             sel_pending;
  logic [3:0]       sel_next;
  logic             push;
  tdc_event_t       push_data;
  tdc_event_t       head;
  logic             fifo_full;
  logic             fifo_empty;

  // Two-flop synchronizer for the asynchronous hasEvent flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_meta <= '0;
      has_sync <= '0;
    end else begin
      has_meta <= tdc_has_event;
      has_sync <= has_meta;
    end
  end

  // First pending channel at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      idx = (int'(rr_ptr) + i) % N_CHANNELS;
      if (!found && has_sync[idx]) begin
        found = 1'b1;
        pick  = 4'(idx);
      end
    end
  end

  // Selected channel's data, pending flag and the channel after it.
  always_comb begin
    push_data      = '0;
    push_data.chan = sel;
    sel_pending    = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (sel == 4'(i)) begin
        push_data.timestamp = tdc_timestamp[32*i +: 32];
        push_data.tot       = tdc_tot[32*i +: 32];
        sel_pending         = has_sync[i];
      end
    end
    sel_next = (sel == 4'(N_CHANNELS - 1)) ? 4'd0 : sel + 4'd1;
  end

  // Collector state and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      rr_ptr      <= '0;
      clr_cnt     <= '0;
      clear_error <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      rr_ptr      <= rr_n;
      clr_cnt     <= cnt_n;
      clear_error <= err_n;
    end
  end

  // Scan, capture into the FIFO, then hold clear until the flag drops or times out.
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    rr_n      = rr_ptr;
    cnt_n     = clr_cnt;
    err_n     = clear_error;
    push      = 1'b0;
    tdc_clear = '0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          sel_n   = pick;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!fifo_full) begin
          push    = 1'b1;
          cnt_n   = '0;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        for (int i = 0; i < N_CHANNELS; i++) begin
          tdc_clear[i] = (sel == 4'(i));
        end
        cnt_n = clr_cnt + 1'b1;
        // clr_cnt+1 cycles of clear have been driven including this one.
        if (!sel_pending && (clr_cnt != '0)) begin
          state_n = IDLE;
          rr_n    = sel_next;
        end else if (clr_cnt == CNT_W'(CLEAR_TIMEOUT - 1)) begin
          state_n = IDLE;
          rr_n    = sel_next;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  tdc_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign evt_valid     = !fifo_empty;
  assign evt_chan      = head.chan;
  assign evt_timestamp = head.timestamp;
  assign evt_tot       = head.tot;

endmodule

// File: tb/tb_tdc_event_collector.sv
// tb/tb_tdc_event_collector.sv - randomized self-checking bench for tdc_event_collector
module tb_tdc_event_collector;

  localparam int N  = 4;
  localparam int FD = 8;
  localparam int TO = 15;

  typedef struct {
    logic [3:0]  chan;
    logic [31:0] ts;
    logic [31:0] tot;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [N-1:0]    has_event;
  logic [32*N-1:0] tdc_timestamp;
  logic [32*N-1:0] tdc_tot;
  logic [N-1:0]    tdc_clear;
  logic            evt_valid;
  logic            evt_ready;
  logic [3:0]      evt_chan;
  logic [31:0]     evt_timestamp;
  logic [31:0]     evt_tot;
  logic [3:0]      fifo_level;
  logic            clear_error;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          rr = 0;
  int          ready_mode = 0;
  bit          dup_mode = 0;
  logic [3:0]  dup_chan = 0;
  logic [N-1:0] stuck = '0;
  int          pops = 0;

  tdc_event_collector #(
    .N_CHANNELS    (N),
    .FIFO_DEPTH    (FD),
    .CLEAR_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .enable        (enable),
    .tdc_has_event (has_event),
    .tdc_timestamp (tdc_timestamp),
    .tdc_tot       (tdc_tot),
    .tdc_clear     (tdc_clear),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_chan      (evt_chan),
    .evt_timestamp (evt_timestamp),
    .evt_tot       (evt_tot),
    .fifo_level    (fifo_level),
    .clear_error   (clear_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One clock: TDC latch model, ready policy, stream scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (tdc_clear[i] && !stuck[i]) has_event[i] = 1'b0;
    end
    if (tdc_clear != '0) check("clear_onehot", 64'($countones(tdc_clear)), 64'd1);
    case (ready_mode)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      default: evt_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (evt_valid && evt_ready) begin
      pops++;
      if (dup_mode) begin
        check("dup_chan", 64'(evt_chan), 64'(dup_chan));
      end else if (exp_q.size() == 0) begin
        check("unexpected_pop", 64'(evt_chan), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("pop_chan", 64'(evt_chan), 64'(e.chan));
        check("pop_ts", 64'(evt_timestamp), 64'(e.ts));
        check("pop_tot", 64'(evt_tot), 64'(e.tot));
      end
    end
  endtask

  // Raise a set of channels at once; they are served in ring order from rr.
  task automatic raise(input logic [N-1:0] mask, input bit fixed,
                       input logic [31:0] fts, input logic [31:0] ftot);
    exp_t e;
    int   c;
    int   last;
    last = rr;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        tdc_timestamp[32*k +: 32] = fixed ? fts : $urandom;
        tdc_tot[32*k +: 32]       = fixed ? ftot : $urandom;
      end
    end
    for (int k = 0; k < N; k++) begin
      c = (rr + k) % N;
      if (mask[c]) begin
        e.chan = 4'(c);
        e.ts   = tdc_timestamp[32*c +: 32];
        e.tot  = tdc_tot[32*c +: 32];
        exp_q.push_back(e);
        last = c;
      end
    end
    rr = (last + 1) % N;
    has_event = has_event | mask;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 400; n++) begin
      step();
      if (has_event == '0 && tdc_clear == '0) break;
    end
    if (n == 400) check("idle_timeout", 64'd1, 64'd0);
    repeat (4) step();
  endtask

  task automatic drain();
    int n;
    ready_mode = 1;
    for (n = 0; n < 200; n++) begin
      step();
      if (!evt_valid) break;
    end
    if (n == 200) check("drain_timeout", 64'd1, 64'd0);
    if (!dup_mode) check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    rr = 0;
  endtask

  initial begin
    int   lat;
    int   clen;
    int   c9;
    exp_t saved;

    rst = 1'b1;
    enable = 1'b1;
    evt_ready = 1'b0;
    has_event = '0;
    tdc_timestamp = '0;
    tdc_tot = '0;
    repeat (3) step();
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_clear", 64'(tdc_clear), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_err", 64'(clear_error), 64'd0);
    check("rst_chan", 64'(evt_chan), 64'd0);
    check("rst_ts", 64'(evt_timestamp), 64'd0);
    check("rst_tot", 64'(evt_tot), 64'd0);
    rst = 1'b0;
    step();

    // Single event on channel 2
    ready_mode = 0;
    raise(4'b0100, 1'b1, 32'h0000_1234, 32'h56);
    for (lat = 1; lat <= 10; lat++) begin
      step();
      if (evt_valid) break;
    end
    check("t1_latency_ok", 64'(lat <= 5), 64'd1);
    check("t1_chan", 64'(evt_chan), 64'd2);
    check("t1_ts", 64'(evt_timestamp), 64'h1234);
    check("t1_tot", 64'(evt_tot), 64'h56);
    clen = 0;
    for (int i = 0; i < 40; i++) begin
      if (tdc_clear[2]) clen++;
      else if (clen > 0) break;
      step();
    end
    check("t1_clear_len_ok", 64'(clen >= 2), 64'd1);
    check("t1_clear_low", 64'(tdc_clear), 64'd0);
    drain();
    wait_idle();

    // Round robin from a fresh pointer: channels 0,1,3
    do_reset();
    ready_mode = 1;
    raise(4'b1011, 1'b0, 0, 0);
    wait_idle();
    drain();

    // Backpressure: eight events fill the FIFO, the ninth waits in capture
    ready_mode = 0;
    raise(4'b1111, 1'b0, 0, 0);
    wait_idle();
    raise(4'b1111, 1'b0, 0, 0);
    wait_idle();
    check("t3_level_full", 64'(fifo_level), 64'd8);
    c9 = $urandom_range(0, N - 1);
    raise(4'(1 << c9), 1'b0, 0, 0);
    repeat (20) step();
    check("t3_level_hold", 64'(fifo_level), 64'd8);
    check("t3_no_clear", 64'(tdc_clear), 64'd0);
    check("t3_still_pending", 64'(has_event[c9]), 64'd1);
    pops = 0;
    ready_mode = 1;
    wait_idle();
    drain();
    check("t3_pops", 64'(pops), 64'd9);

    // Clear timeout on a stuck channel 1
    ready_mode = 1;
    dup_mode = 1'b1;
    dup_chan = 4'd1;
    stuck[1] = 1'b1;
    pops = 0;
    tdc_timestamp[32 +: 32] = $urandom;
    tdc_tot[32 +: 32] = $urandom;
    has_event[1] = 1'b1;
    clen = 0;
    for (lat = 0; lat < 100; lat++) begin
      step();
      if (clear_error) break;
      if (tdc_clear[1]) clen++;
    end
    check("t4_err_set", 64'(clear_error), 64'd1);
    check("t4_clear_cycles", 64'(clen), 64'(TO));
    check("t4_back_idle", 64'(tdc_clear), 64'd0);
    stuck[1] = 1'b0;
    wait_idle();
    drain();
    check("t4_dup_ok", 64'(pops >= 2), 64'd1);
    check("t4_sticky", 64'(clear_error), 64'd1);
    dup_mode = 1'b0;
    rr = 2;

    // Reset in the middle of clearing channel 3
    ready_mode = 0;
    stuck[3] = 1'b1;
    raise(4'b1000, 1'b0, 0, 0);
    saved = exp_q[$];
    for (lat = 0; lat < 20; lat++) begin
      step();
      if (tdc_clear[3]) break;
    end
    check("t5_in_clear", 64'(tdc_clear), 64'h8);
    rst = 1'b1;
    #1;
    check("t5_rst_clear", 64'(tdc_clear), 64'd0);
    check("t5_rst_valid", 64'(evt_valid), 64'd0);
    check("t5_rst_level", 64'(fifo_level), 64'd0);
    check("t5_rst_err", 64'(clear_error), 64'd0);
    step();
    rst = 1'b0;
    stuck[3] = 1'b0;
    exp_q.delete();
    exp_q.push_back(saved);
    rr = 0;
    pops = 0;
    ready_mode = 1;
    wait_idle();
    drain();
    check("t5_once", 64'(pops), 64'd1);

    // Enable gating with channel 0 pending
    ready_mode = 0;
    enable = 1'b0;
    raise(4'b0001, 1'b0, 0, 0);
    repeat (10) step();
    check("t6_no_clear", 64'(tdc_clear), 64'd0);
    check("t6_no_level", 64'(fifo_level), 64'd0);
    check("t6_no_valid", 64'(evt_valid), 64'd0);
    enable = 1'b1;
    for (lat = 1; lat <= 10; lat++) begin
      step();
      if (evt_valid) break;
    end
    check("t6_latency_ok", 64'(lat <= 3), 64'd1);
    wait_idle();
    drain();

    // Random batches with random readiness
    ready_mode = 2;
    for (int b = 0; b < 30; b++) begin
      raise(4'($urandom_range(1, 15)), 1'b0, 0, 0);
      wait_idle();
    end
    drain();
    check("end_err_clear", 64'(clear_error), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
